// File: rtl/fx2_slave_fifo_responder_if.sv
// FX2 slave-FIFO bus between the FPGA host interface (master) and the
// USB-chip end (slave).
//   fx2_hics_b/sloe_b/slrd_b/slwr_b/pktend_b : active-low strobes from master
//   fx2_fifo_addr : endpoint select (00=EP2, 10=EP6)
//   fx2_fd_in     : data master -> slave
//   fx2_fd_out    : data slave -> master, fx2_fd_oe its drive enable
//   fx2_flags     : [0] EP2 not-empty, [1] EP6 not-full, [2] EP6 not-almost-full
interface fx2_slave_fifo_responder_if;
  logic        fx2_hics_b;
  logic        fx2_sloe_b;
  logic        fx2_slrd_b;
  logic        fx2_slwr_b;
  logic        fx2_pktend_b;
  logic [1:0]  fx2_fifo_addr;
  logic [15:0] fx2_fd_in;
  logic [15:0] fx2_fd_out;
  logic        fx2_fd_oe;
  logic [2:0]  fx2_flags;

  modport master (
    output fx2_hics_b, fx2_sloe_b, fx2_slrd_b, fx2_slwr_b, fx2_pktend_b,
    output fx2_fifo_addr, fx2_fd_in,
    input  fx2_fd_out, fx2_fd_oe, fx2_flags
  );

  modport slave (
    input  fx2_hics_b, fx2_sloe_b, fx2_slrd_b, fx2_slwr_b, fx2_pktend_b,
    input  fx2_fifo_addr, fx2_fd_in,
    output fx2_fd_out, fx2_fd_oe, fx2_flags
  );
endinterface

// File: rtl/fx2_slave_fifo_responder.sv
// FX2 slave-FIFO responder: emulates the USB-chip end of the 16-bit FX2
// slave-FIFO bus. EP2 (host -> FPGA) is filled from a host stream and read by
// the FPGA with FWFT data; EP6 (FPGA -> host) is written by the FPGA and
// committed in packets (auto at PKT_WORDS or on pktend) before the host
// stream can drain it.
// Ports:
//   clk, reset   : bus clock, synchronous active-high reset
//   fx2          : FX2 bus, slave modport
//   out_data_i/out_valid_i/out_ready_o : host stream into EP2
//   in_data_o/in_valid_o/in_ready_i/in_last_o : committed EP6 stream to host
//   err_count_o  : saturating protocol-error count
// Optional feature: define FX2_PROTO_CHECK_EN to enable protocol-error
// counting; otherwise err_count_o is tied to zero.
module fx2_slave_fifo_responder #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned PKT_WORDS  = 256,
  parameter int unsigned AFULL_FREE = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  fx2_slave_fifo_responder_if.slave        fx2,
  input  logic [15:0]                      out_data_i,
  input  logic                             out_valid_i,
  output logic                             out_ready_o,
  output logic [15:0]                      in_data_o,
  output logic                             in_valid_o,
  input  logic                             in_ready_i,
  output logic                             in_last_o,
  output logic [7:0]                       err_count_o
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DEPTH_P = PW'(DEPTH);
  localparam ptr_t PKT_P   = PW'(PKT_WORDS);
  localparam ptr_t AFULL_P = PW'(AFULL_FREE);

  // Storage
  logic [DW-1:0] ep2_mem  [DEPTH];
  logic [DW-1:0] ep6_data [DEPTH];
  logic          ep6_last [DEPTH];

  // State
  ptr_t          ep2_wp_q, ep2_rp_q, ep6_wp_q, ep6_cp_q, ep6_rp_q;
  ptr_t          ep2_wp_d, ep2_rp_d, ep6_wp_d, ep6_cp_d, ep6_rp_d;
  logic [DW-1:0] fd_out_q, fd_out_d;
  logic [2:0]    flags_q, flags_d;
  logic          out_ready_q, out_ready_d;
  logic [DW-1:0] in_data_q, in_data_d;
  logic          in_valid_q, in_valid_d;
  logic          in_last_q, in_last_d;

  // Decode
  logic    sel_ep2, sel_ep6;
  logic    ep2_push, ep2_pop;
  logic    ep6_wr, ep6_pkt, ep6_commit, ep6_full;
  logic    lst_we;
  ptr_t    lst_addr;
  ptr_t    ep2_cnt, ep2_cnt_d;
  ptr_t    ep6_used, ep6_used_d, ep6_unc_new;
  logic [AW-1:0] ridx;

  assign sel_ep2 = !fx2.fx2_hics_b && (fx2.fx2_fifo_addr == 2'b00);
  assign sel_ep6 = !fx2.fx2_hics_b && (fx2.fx2_fifo_addr == 2'b10);

  // Bus drive enable is combinational so the FPGA sees it in the same cycle.
  assign fx2.fx2_fd_oe  = sel_ep2 && !fx2.fx2_sloe_b;
  assign fx2.fx2_fd_out = fd_out_q;
  assign fx2.fx2_flags  = flags_q;

  assign out_ready_o = out_ready_q;
  assign in_data_o   = in_data_q;
  assign in_valid_o  = in_valid_q;
  assign in_last_o   = in_last_q;

  // EP2 next state and FWFT head
  always_comb begin
    ep2_cnt   = ep2_wp_q - ep2_rp_q;
    ep2_push  = out_valid_i && out_ready_q;
    ep2_pop   = sel_ep2 && !fx2.fx2_slrd_b && (ep2_cnt != '0);
    ep2_wp_d  = ep2_wp_q + PW'(ep2_push);
    ep2_rp_d  = ep2_rp_q + PW'(ep2_pop);
    ep2_cnt_d = ep2_wp_d - ep2_rp_d;
    out_ready_d = (ep2_cnt_d != DEPTH_P);
    fd_out_d  = fd_out_q;
    if (ep2_cnt_d != '0) begin
      // Head equal to the old write pointer means it is the word pushed now.
      if (ep2_rp_d == ep2_wp_q) fd_out_d = out_data_i;
      else                      fd_out_d = ep2_mem[ep2_rp_d[AW-1:0]];
    end
  end

  // EP6 write / commit / host drain
  always_comb begin
    ep6_used    = ep6_wp_q - ep6_rp_q;
    ep6_full    = (ep6_used == DEPTH_P);
    ep6_wr      = sel_ep6 && !fx2.fx2_slwr_b && !ep6_full;
    ep6_pkt     = sel_ep6 && !fx2.fx2_pktend_b;
    ep6_unc_new = (ep6_wp_q - ep6_cp_q) + PW'(ep6_wr);
    ep6_commit  = (ep6_wr && (ep6_unc_new == PKT_P)) ||
                  (ep6_pkt && (ep6_unc_new != '0));
    ep6_wp_d    = ep6_wp_q + PW'(ep6_wr);
    ep6_cp_d    = ep6_commit ? ep6_wp_d : ep6_cp_q;
    ep6_rp_d    = ep6_rp_q + PW'(in_valid_q && in_ready_i);
    ep6_used_d  = ep6_wp_d - ep6_rp_d;
    // Every write stores its last bit; a pktend-only commit re-marks the
    // most recently written word.
    lst_we      = ep6_wr || ep6_commit;
    lst_addr    = ep6_wr ? ep6_wp_q : (ep6_wp_q - PW'(1));
    ridx        = ep6_rp_d[AW-1:0];
    in_valid_d  = (ep6_cp_d != ep6_rp_d);
    if (ep6_wr && (ep6_wp_q[AW-1:0] == ridx)) in_data_d = fx2.fx2_fd_in;
    else                                      in_data_d = ep6_data[ridx];
    if (lst_we && (lst_addr[AW-1:0] == ridx)) in_last_d = in_valid_d && ep6_commit;
    else                                      in_last_d = in_valid_d && ep6_last[ridx];
    flags_d = {((DEPTH_P - ep6_used_d) >= AFULL_P),
               (ep6_used_d != DEPTH_P),
               (ep2_cnt_d != '0)};
  end

  // Buffer storage (no reset needed; pointers define validity)
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ep2_push) ep2_mem[ep2_wp_q[AW-1:0]]  <= out_data_i;
      if (ep6_wr)   ep6_data[ep6_wp_q[AW-1:0]] <= fx2.fx2_fd_in;
      if (lst_we)   ep6_last[lst_addr[AW-1:0]] <= ep6_commit;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ep2_wp_q    <= '0;
      ep2_rp_q    <= '0;
      ep6_wp_q    <= '0;
      ep6_cp_q    <= '0;
      ep6_rp_q    <= '0;
      fd_out_q    <= '0;
      flags_q     <= 3'b110;
      out_ready_q <= 1'b1;
      in_data_q   <= '0;
      in_valid_q  <= 1'b0;
      in_last_q   <= 1'b0;
    end else begin
      ep2_wp_q    <= ep2_wp_d;
      ep2_rp_q    <= ep2_rp_d;
      ep6_wp_q    <= ep6_wp_d;
      ep6_cp_q    <= ep6_cp_d;
      ep6_rp_q    <= ep6_rp_d;
      fd_out_q    <= fd_out_d;
      flags_q     <= flags_d;
      out_ready_q <= out_ready_d;
      in_data_q   <= in_data_d;
      in_valid_q  <= in_valid_d;
      in_last_q   <= in_last_d;
    end
  end

`ifdef FX2_PROTO_CHECK_EN
  // Protocol-error counter, saturating at 255
  logic [7:0] err_q, err_d;
  logic       err_ev;

  always_comb begin
    err_ev = !fx2.fx2_hics_b && (
               (sel_ep2 && !fx2.fx2_slrd_b && (ep2_cnt == '0)) ||
               (sel_ep6 && !fx2.fx2_slwr_b && ep6_full) ||
               (!fx2.fx2_slrd_b && !fx2.fx2_slwr_b) ||
               (fx2.fx2_fifo_addr[0] &&
                (!fx2.fx2_slrd_b || !fx2.fx2_slwr_b || !fx2.fx2_pktend_b)));
    err_d = err_q;
    if (err_ev && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_count_o = err_q;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_fx2_slave_fifo_responder.sv
// Directed bench for fx2_slave_fifo_responder: EP2 FWFT reads, EP6 auto and
// pktend commits, full/almost-full flags, same-edge pktend, reset mid-packet.
module tb_fx2_slave_fifo_responder;

`ifdef FX2_PROTO_CHECK_EN
  localparam logic [7:0] EXP_ERR = 8'd1;
`else
  localparam logic [7:0] EXP_ERR = 8'd0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  fx2_slave_fifo_responder_if bus();

  fx2_slave_fifo_responder dut (
    .clk         (clk),
    .reset       (reset),
    .fx2         (bus.slave),
    .out_data_i  (out_data),
    .out_valid_i (out_valid),
    .out_ready_o (out_ready),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .in_last_o   (in_last),
    .err_count_o (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.fx2_hics_b    = 1'b1;
    bus.fx2_sloe_b    = 1'b1;
    bus.fx2_slrd_b    = 1'b1;
    bus.fx2_slwr_b    = 1'b1;
    bus.fx2_pktend_b  = 1'b1;
    bus.fx2_fifo_addr = 2'b00;
    bus.fx2_fd_in     = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_valid = 1'b0; out_data = 16'h0; in_ready = 1'b0;
    idle_bus();
    tick(); tick();
    checks++; if (bus.fx2_flags !== 3'b110) begin errors++; $display("FAIL reset_flags: got %b want 110", bus.fx2_flags); end
    checks++; if (bus.fx2_fd_out !== 16'h0) begin errors++; $display("FAIL reset_fd_out: got %h want 0000", bus.fx2_fd_out); end
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_out_ready: got %b want 1", out_ready); end
    checks++; if (in_valid !== 1'b0 || in_last !== 1'b0) begin errors++; $display("FAIL reset_in: got valid=%b last=%b want 0 0", in_valid, in_last); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
    bus.fx2_hics_b = 1'b0; bus.fx2_sloe_b = 1'b0; bus.fx2_fifo_addr = 2'b00; #1;
    checks++; if (bus.fx2_fd_oe !== 1'b1) begin errors++; $display("FAIL oe_ep2: got %b want 1", bus.fx2_fd_oe); end
    bus.fx2_fifo_addr = 2'b10; #1;
    checks++; if (bus.fx2_fd_oe !== 1'b0) begin errors++; $display("FAIL oe_ep6: got %b want 0", bus.fx2_fd_oe); end
    idle_bus();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ep2_read();
    for (int i = 1; i <= 4; i++) begin
      out_valid = 1'b1; out_data = 16'(i); tick();
    end
    out_valid = 1'b0;
    checks++; if (bus.fx2_fd_out !== 16'h0001 || bus.fx2_flags[0] !== 1'b1) begin errors++; $display("FAIL ep2_fill: got fd=%h f0=%b want 0001 1", bus.fx2_fd_out, bus.fx2_flags[0]); end
    bus.fx2_hics_b = 1'b0; bus.fx2_sloe_b = 1'b0; bus.fx2_fifo_addr = 2'b00; bus.fx2_slrd_b = 1'b0; #1;
    checks++; if (bus.fx2_fd_oe !== 1'b1) begin errors++; $display("FAIL ep2_oe: got %b want 1", bus.fx2_fd_oe); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (bus.fx2_fd_out !== 16'(k) || bus.fx2_flags[0] !== 1'b1) begin errors++; $display("FAIL ep2_pop%0d: got fd=%h f0=%b want %h 1", k, bus.fx2_fd_out, bus.fx2_flags[0], 16'(k)); end
      tick();
    end
    idle_bus();
    checks++; if (bus.fx2_flags[0] !== 1'b0 || bus.fx2_fd_out !== 16'h0004) begin errors++; $display("FAIL ep2_empty: got f0=%b fd=%h want 0 0004", bus.fx2_flags[0], bus.fx2_fd_out); end
  endtask

  task automatic test_back_to_back();
    out_valid = 1'b1; out_data = 16'h0050; tick();
    checks++; if (bus.fx2_fd_out !== 16'h0050) begin errors++; $display("FAIL b2b_first: got %h want 0050", bus.fx2_fd_out); end
    bus.fx2_hics_b = 1'b0; bus.fx2_fifo_addr = 2'b00; bus.fx2_slrd_b = 1'b0; out_data = 16'h0051; tick();
    checks++; if (bus.fx2_fd_out !== 16'h0051 || bus.fx2_flags[0] !== 1'b1) begin errors++; $display("FAIL b2b_pushpop: got fd=%h f0=%b want 0051 1", bus.fx2_fd_out, bus.fx2_flags[0]); end
    out_valid = 1'b0; tick();
    idle_bus();
    checks++; if (bus.fx2_fd_out !== 16'h0051 || bus.fx2_flags[0] !== 1'b0) begin errors++; $display("FAIL b2b_drain: got fd=%h f0=%b want 0051 0", bus.fx2_fd_out, bus.fx2_flags[0]); end
  endtask

  task automatic test_ep6_packet();
    bus.fx2_hics_b = 1'b0; bus.fx2_fifo_addr = 2'b10; bus.fx2_slwr_b = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.fx2_fd_in = 16'h0100 + 16'(i);
      if (i == 255) begin
        checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL pkt_early: got in_valid=%b want 0", in_valid); end
      end
      tick();
    end
    idle_bus();
    checks++; if (in_valid !== 1'b1 || in_data !== 16'h0100) begin errors++; $display("FAIL pkt_commit: got v=%b d=%h want 1 0100", in_valid, in_data); end
    in_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (in_valid !== 1'b1 || in_data !== 16'h0100 + 16'(i) || in_last !== (i == 255)) begin
        errors++; $display("FAIL pkt_word%0d: got v=%b d=%h l=%b want 1 %h %b", i, in_valid, in_data, in_last, 16'h0100 + 16'(i), (i == 255));
      end
      tick();
    end
    in_ready = 1'b0;
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL pkt_drained: got in_valid=%b want 0", in_valid); end
  endtask

  task automatic test_pktend();
    bus.fx2_hics_b = 1'b0; bus.fx2_fifo_addr = 2'b10;
    for (int i = 0; i < 3; i++) begin
      bus.fx2_slwr_b = 1'b0; bus.fx2_fd_in = 16'hA000 + 16'(i); tick();
    end
    bus.fx2_slwr_b = 1'b1;
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL pe_uncommitted: got in_valid=%b want 0", in_valid); end
    bus.fx2_pktend_b = 1'b0; tick(); bus.fx2_pktend_b = 1'b1;
    in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_valid !== 1'b1 || in_data !== 16'hA000 + 16'(i) || in_last !== (i == 2)) begin
        errors++; $display("FAIL pe_word%0d: got v=%b d=%h l=%b want 1 %h %b", i, in_valid, in_data, in_last, 16'hA000 + 16'(i), (i == 2));
      end
      tick();
    end
    in_ready = 1'b0;
    bus.fx2_pktend_b = 1'b0; tick(); bus.fx2_pktend_b = 1'b1; tick();
    idle_bus();
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL pe_zlp: got in_valid=%b want 0", in_valid); end
  endtask

  task automatic test_fill();
    bus.fx2_hics_b = 1'b0; bus.fx2_fifo_addr = 2'b10; bus.fx2_slwr_b = 1'b0;
    for (int i = 1; i <= 512; i++) begin
      bus.fx2_fd_in = 16'(i - 1); tick();
      if (i == 508) begin checks++; if (bus.fx2_flags[2] !== 1'b1) begin errors++; $display("FAIL fill_afull508: got %b want 1", bus.fx2_flags[2]); end end
      if (i == 509) begin checks++; if (bus.fx2_flags[2] !== 1'b0) begin errors++; $display("FAIL fill_afull509: got %b want 0", bus.fx2_flags[2]); end end
      if (i == 511) begin checks++; if (bus.fx2_flags[1] !== 1'b1) begin errors++; $display("FAIL fill_full511: got %b want 1", bus.fx2_flags[1]); end end
      if (i == 512) begin checks++; if (bus.fx2_flags[1] !== 1'b0) begin errors++; $display("FAIL fill_full512: got %b want 0", bus.fx2_flags[1]); end end
    end
    bus.fx2_fd_in = 16'hDEAD; tick();
    idle_bus();
    checks++; if (err_count !== EXP_ERR) begin errors++; $display("FAIL fill_err: got %0d want %0d", err_count, EXP_ERR); end
    checks++; if (bus.fx2_flags !== 3'b000) begin errors++; $display("FAIL fill_flags: got %b want 000", bus.fx2_flags); end
    in_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      checks++;
      if (in_valid !== 1'b1 || in_data !== 16'(i) || in_last !== (i == 255 || i == 511)) begin
        errors++; $display("FAIL fill_word%0d: got v=%b d=%h l=%b want 1 %h %b", i, in_valid, in_data, in_last, 16'(i), (i == 255 || i == 511));
      end
      tick();
    end
    in_ready = 1'b0;
    checks++; if (in_valid !== 1'b0 || bus.fx2_flags !== 3'b110) begin errors++; $display("FAIL fill_drained: got v=%b flags=%b want 0 110", in_valid, bus.fx2_flags); end
  endtask

  task automatic test_same_edge_pktend();
    bus.fx2_hics_b = 1'b0; bus.fx2_fifo_addr = 2'b10;
    for (int i = 1; i <= 5; i++) begin
      bus.fx2_slwr_b = 1'b0; bus.fx2_pktend_b = (i == 5) ? 1'b0 : 1'b1;
      bus.fx2_fd_in = 16'hB000 + 16'(i); tick();
    end
    idle_bus();
    in_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (in_valid !== 1'b1 || in_data !== 16'hB000 + 16'(i) || in_last !== (i == 5)) begin
        errors++; $display("FAIL se_word%0d: got v=%b d=%h l=%b want 1 %h %b", i, in_valid, in_data, in_last, 16'hB000 + 16'(i), (i == 5));
      end
      tick();
    end
    in_ready = 1'b0;
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL se_drained: got in_valid=%b want 0", in_valid); end
  endtask

  task automatic test_reset_mid_packet();
    bus.fx2_hics_b = 1'b0; bus.fx2_fifo_addr = 2'b10;
    for (int i = 1; i <= 5; i++) begin
      bus.fx2_slwr_b = 1'b0; bus.fx2_pktend_b = (i == 2) ? 1'b0 : 1'b1;
      bus.fx2_fd_in = 16'hC000 + 16'(i); tick();
    end
    idle_bus();
    checks++; if (in_valid !== 1'b1) begin errors++; $display("FAIL rm_precommit: got in_valid=%b want 1", in_valid); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (in_valid !== 1'b0 || bus.fx2_flags !== 3'b110 || err_count !== 8'd0) begin errors++; $display("FAIL rm_reset: got v=%b flags=%b err=%0d want 0 110 0", in_valid, bus.fx2_flags, err_count); end
    bus.fx2_hics_b = 1'b0; bus.fx2_fifo_addr = 2'b10; bus.fx2_pktend_b = 1'b0; tick(); bus.fx2_pktend_b = 1'b1;
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL rm_stale: got in_valid=%b want 0", in_valid); end
    bus.fx2_slwr_b = 1'b0; bus.fx2_pktend_b = 1'b0; bus.fx2_fd_in = 16'hD00D; tick();
    idle_bus();
    checks++; if (in_valid !== 1'b1 || in_data !== 16'hD00D || in_last !== 1'b1) begin errors++; $display("FAIL rm_fresh: got v=%b d=%h l=%b want 1 d00d 1", in_valid, in_data, in_last); end
    in_ready = 1'b1; tick(); in_ready = 1'b0;
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL rm_drained: got in_valid=%b want 0", in_valid); end
  endtask

  initial begin
    test_reset();
    test_ep2_read();
    test_back_to_back();
    test_ep6_packet();
    test_pktend();
    test_fill();
    test_same_edge_pktend();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
